vga_sprite_engine: RTL and testbench
====================================

# vga_sprite_engine

Multi-channel horizontal sprite generator for the VGA pixel pipeline. It generalises the single fixed 16-pixel sprite to NUM_SPRITES independent channels, each with its own width, colour depth, scale, mirror and enable settings. Settings are double-buffered and committed once per line. A fixed-priority mux merges the channels into one registered colour index, with a sticky per-frame collision flag. The block sits between the line-buffer/config register file and the palette lookup.

## Interface
- NUM_SPRITES, 4: number of sprite channels (1..8)
- SPRITE_WIDTH, 16: pixels per sprite row (power of two, 4..32)
- COLOR_BITS, 2: bits per colour index; index 0 is transparent
- SCALE_BITS, 6: width of the per-sprite scale field
- H_BITS, 10: width of the horizontal counter
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-high
- h_counter  in  H_BITS  current horizontal pixel position
- line_start  in  1  one-cycle pulse at start of horizontal blanking
- frame_start  in  1  one-cycle pulse at start of frame; clears collision
- wr_en  in  1  write pending config of channel wr_sel
- wr_sel  in  $clog2(NUM_SPRITES) (min 1)  target channel
- wr_pixels  in  SPRITE_WIDTH*COLOR_BITS  row data; pixel p at [p*COLOR_BITS +: COLOR_BITS]
- wr_x  in  H_BITS  start position
- wr_scale  in  SCALE_BITS  each pixel lasts wr_scale+1 cycles
- wr_flip  in  1  1 = emit pixels SPRITE_WIDTH-1 down to 0
- wr_enable  in  1  channel enable
- color_out  out  COLOR_BITS  merged colour index, registered
- sprite_hit  out  1  color_out comes from a sprite (nonzero)
- sprite_id  out  $clog2(NUM_SPRITES) (min 1)  winning channel; 0 when no hit
- collision  out  1  sticky: two or more channels were opaque on the same cycle this frame

## Operation
- Each channel has pending and live config registers. wr_en updates the pending copy only.
- line_start copies all pending to live, and aborts every channel: active=0, counters=0.
- A wr_en coinciding with line_start is written to pending. It is not part of that commit; it takes effect at the next line_start.
- Channel states are IDLE and ACTIVE.
  - IDLE→ACTIVE when the live enable is set and h_counter == live x.
  - A match while ACTIVE is ignored; the pass is not restarted.
  - ACTIVE→IDLE after the last sub-cycle of the last pixel, on line_start, or on reset.
- Counters per channel:
  - sub_count runs 0..scale, then wraps and increments pixel_count.
  - pixel_count runs 0..SPRITE_WIDTH-1.
  - Emitted pixel index = flip ? SPRITE_WIDTH-1-pixel_count : pixel_count.
- A channel's index is 0 when it is IDLE. An opaque pixel is one with a nonzero index.
- Merge: the lowest-numbered channel with an opaque pixel wins. No opaque channel gives color_out=0, sprite_hit=0, sprite_id=0.
- Collision: set when ≥2 channels are opaque in the same cycle, and held until frame_start. If set and frame_start coincide, set wins.
- No wrap on the line: a sprite whose x+length exceeds the line continues until it completes or line_start aborts it.
- Scale of 0 gives 1 cycle per pixel. The maximum scale gives 2^SCALE_BITS cycles per pixel.
- Reset clears pending, live, counters and all outputs to 0.

## Timing
- Channel stage: the match at cycle T makes the channel ACTIVE at T+1, and its index is valid combinationally during T+1.
- Merge stage: registered, so pixel p, sub-cycle s appears on color_out in the cycle where h_counter == x + 2 + p*(scale+1) + s.
- Total pipeline latency is 2 cycles. Downstream compensates.
- A pass lasts SPRITE_WIDTH*(scale+1) cycles.
- collision rises in the same cycle as the color_out showing the overlap.
- The commit is visible to a match in the cycle after line_start.
- Outputs are 0 in the cycle after reset is sampled high.

## Structure
- Package vga_sprite_pkg holds:
  - default parameter constants;
  - the transparent index constant (0);
  - localparam helper ID_BITS = max(1, $clog2(NUM_SPRITES)).
- Sub-module vga_sprite_channel, instanced per channel via generate, contains:
  - pending and live config;
  - the IDLE/ACTIVE state;
  - the counters and pixel select, including flip.
- The top level holds the write decode, the priority merge, the collision logic and the output registers.

## Test plan
- Single channel, x=100, scale=0, no flip, pixels 0x1B (pixel 0 = 3): color_out=3 at h_counter=102, then 2, 1, 0; idle after 16 cycles.
- Same data with scale=2 and flip=1: the pixel-15 value is held 3 cycles starting at h_counter=102, and the pass spans 48 cycles.
- Channels 0 and 1 overlapping, both opaque: sprite_id=0, and collision rises at the first overlapping output and stays set until frame_start.
  - Channel 0 transparent in the overlap: sprite_id=1 and no collision.
- wr_en coinciding with line_start, with a new x: the old x is used on the next line and the new x on the line after. Writing mid-line does not alter the active pass.
- A second x match during a pass (pending x rewritten, then committed) is ignored. line_start mid-pass aborts: color_out=0 two cycles later.
- reset asserted mid-pass: all outputs 0 the next cycle, and the channel stays idle until reconfigured, because enable is cleared.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared constants and types for the multi-channel horizontal sprite engine.
package vga_sprite_pkg;

   localparam int NUM_SPRITES_DEF  = 4;
   localparam int SPRITE_WIDTH_DEF = 16;
   localparam int COLOR_BITS_DEF   = 2;
   localparam int SCALE_BITS_DEF   = 6;
   localparam int H_BITS_DEF       = 10;

   localparam int TRANSPARENT_IDX  = 0;

   function automatic int id_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_BITS = id_bits(NUM_SPRITES_DEF);

   typedef enum logic {
      CH_IDLE   = 1'b0,
      CH_ACTIVE = 1'b1
   } ch_state_e;

endpackage

// File: rtl/vga_sprite_engine_if.sv
// Config write bus from the register file into the sprite engine.
interface vga_sprite_engine_if
   import vga_sprite_pkg::*;
#(
   parameter int NUM_SPRITES  = NUM_SPRITES_DEF,
   parameter int SPRITE_WIDTH = SPRITE_WIDTH_DEF,
   parameter int COLOR_BITS   = COLOR_BITS_DEF,
   parameter int SCALE_BITS   = SCALE_BITS_DEF,
   parameter int H_BITS       = H_BITS_DEF
) ();
   localparam int ID_W = id_bits(NUM_SPRITES);

   logic                               wr_en;
   logic [ID_W-1:0]                    wr_sel;
   logic [SPRITE_WIDTH*COLOR_BITS-1:0] wr_pixels;
   logic [H_BITS-1:0]                  wr_x;
   logic [SCALE_BITS-1:0]              wr_scale;
   logic                               wr_flip;
   logic                               wr_enable;

   modport master (output wr_en, wr_sel, wr_pixels, wr_x, wr_scale, wr_flip, wr_enable);
   modport slave  (input  wr_en, wr_sel, wr_pixels, wr_x, wr_scale, wr_flip, wr_enable);
endinterface

// File: rtl/vga_sprite_channel.sv
// One sprite channel: double-buffered config, IDLE/ACTIVE pass FSM and
// pixel/sub-cycle counters producing this channel's colour index.
module vga_sprite_channel
   import vga_sprite_pkg::*;
#(
   parameter int SPRITE_WIDTH = SPRITE_WIDTH_DEF,
   parameter int COLOR_BITS   = COLOR_BITS_DEF,
   parameter int SCALE_BITS   = SCALE_BITS_DEF,
   parameter int H_BITS       = H_BITS_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_line_start,
   input  logic [H_BITS-1:0]                  i_h_counter,
   input  logic                               i_wr,
   input  logic [SPRITE_WIDTH*COLOR_BITS-1:0] i_wr_pixels,
   input  logic [H_BITS-1:0]                  i_wr_x,
   input  logic [SCALE_BITS-1:0]              i_wr_scale,
   input  logic                               i_wr_flip,
   input  logic                               i_wr_enable,
   output logic [COLOR_BITS-1:0]              o_color
);
   localparam int PIX_BITS = $clog2(SPRITE_WIDTH);

   logic [SPRITE_WIDTH*COLOR_BITS-1:0] r_pend_pixels, r_live_pixels;
   logic [H_BITS-1:0]                  r_pend_x,      r_live_x;
   logic [SCALE_BITS-1:0]              r_pend_scale,  r_live_scale;
   logic                               r_pend_flip,   r_live_flip;
   logic                               r_pend_en,     r_live_en;

   ch_state_e             r_state, w_state_nxt;
   logic [SCALE_BITS-1:0] r_sub;
   logic [PIX_BITS-1:0]   r_pix;
   logic [PIX_BITS-1:0]   w_idx;
   logic                  w_last;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend_pixels <= '0;
         r_pend_x      <= '0;
         r_pend_scale  <= '0;
         r_pend_flip   <= 1'b0;
         r_pend_en     <= 1'b0;
      end else if (i_wr) begin
         r_pend_pixels <= i_wr_pixels;
         r_pend_x      <= i_wr_x;
         r_pend_scale  <= i_wr_scale;
         r_pend_flip   <= i_wr_flip;
         r_pend_en     <= i_wr_enable;
      end
   end

   // Live takes the pending value held before this edge, so a write landing
   // on the same cycle as line_start waits for the following line.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_live_pixels <= '0;
         r_live_x      <= '0;
         r_live_scale  <= '0;
         r_live_flip   <= 1'b0;
         r_live_en     <= 1'b0;
      end else if (i_line_start) begin
         r_live_pixels <= r_pend_pixels;
         r_live_x      <= r_pend_x;
         r_live_scale  <= r_pend_scale;
         r_live_flip   <= r_pend_flip;
         r_live_en     <= r_pend_en;
      end
   end

   assign w_last = (r_sub == r_live_scale) && (&r_pix);

   always_ff @(posedge clk) begin
      if (reset) r_state <= CH_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CH_IDLE:   if (r_live_en && (i_h_counter == r_live_x)) w_state_nxt = CH_ACTIVE;
         CH_ACTIVE: if (w_last) w_state_nxt = CH_IDLE;
         default:   w_state_nxt = CH_IDLE;
      endcase
      if (i_line_start) w_state_nxt = CH_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset || i_line_start || (r_state == CH_IDLE)) begin
         r_sub <= '0;
         r_pix <= '0;
      end else if (r_sub == r_live_scale) begin
         r_sub <= '0;
         r_pix <= r_pix + 1'b1;
      end else begin
         r_sub <= r_sub + 1'b1;
      end
   end

   // SPRITE_WIDTH is a power of two, so WIDTH-1-pix is the bitwise inverse.
   assign w_idx   = r_live_flip ? ~r_pix : r_pix;
   assign o_color = (r_state == CH_ACTIVE) ?
                    r_live_pixels[int'(w_idx)*COLOR_BITS +: COLOR_BITS] : '0;

endmodule

// File: rtl/vga_sprite_engine.sv
// Multi-channel sprite generator: write decode, per-channel sprite units,
// fixed-priority merge and sticky per-frame collision flag.
module vga_sprite_engine
   import vga_sprite_pkg::*;
#(
   parameter int NUM_SPRITES  = NUM_SPRITES_DEF,
   parameter int SPRITE_WIDTH = SPRITE_WIDTH_DEF,
   parameter int COLOR_BITS   = COLOR_BITS_DEF,
   parameter int SCALE_BITS   = SCALE_BITS_DEF,
   parameter int H_BITS       = H_BITS_DEF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [H_BITS-1:0]                 i_h_counter,
   input  logic                              i_line_start,
   input  logic                              i_frame_start,
   vga_sprite_engine_if.slave                wr_bus,
   output logic [COLOR_BITS-1:0]             o_color_out,
   output logic                              o_sprite_hit,
   output logic [id_bits(NUM_SPRITES)-1:0]   o_sprite_id,
   output logic                              o_collision
);
   localparam int ID_W = id_bits(NUM_SPRITES);

   logic [NUM_SPRITES-1:0]                 w_wr;
   logic [NUM_SPRITES-1:0][COLOR_BITS-1:0] w_color;
   logic [COLOR_BITS-1:0]                  w_sel_color;
   logic [ID_W-1:0]                        w_sel_id;
   logic                                   w_hit;
   logic                                   w_multi;

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_ch
      assign w_wr[g] = wr_bus.wr_en && (wr_bus.wr_sel == ID_W'(g));

      vga_sprite_channel #(
         .SPRITE_WIDTH (SPRITE_WIDTH),
         .COLOR_BITS   (COLOR_BITS),
         .SCALE_BITS   (SCALE_BITS),
         .H_BITS       (H_BITS)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .i_line_start (i_line_start),
         .i_h_counter  (i_h_counter),
         .i_wr         (w_wr[g]),
         .i_wr_pixels  (wr_bus.wr_pixels),
         .i_wr_x       (wr_bus.wr_x),
         .i_wr_scale   (wr_bus.wr_scale),
         .i_wr_flip    (wr_bus.wr_flip),
         .i_wr_enable  (wr_bus.wr_enable),
         .o_color      (w_color[g])
      );
   end

   // Scan high to low so the lowest opaque channel is the last to claim.
   always_comb begin
      w_sel_color = '0;
      w_sel_id    = '0;
      w_hit       = 1'b0;
      w_multi     = 1'b0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (w_color[i] != COLOR_BITS'(TRANSPARENT_IDX)) begin
            if (w_hit) w_multi = 1'b1;
            w_hit       = 1'b1;
            w_sel_color = w_color[i];
            w_sel_id    = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_color_out  <= '0;
         o_sprite_hit <= 1'b0;
         o_sprite_id  <= '0;
         o_collision  <= 1'b0;
      end else begin
         o_color_out  <= w_sel_color;
         o_sprite_hit <= w_hit;
         o_sprite_id  <= w_sel_id;
         if (w_multi)            o_collision <= 1'b1;
         else if (i_frame_start) o_collision <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: single channel, scale/flip, overlap,
// commit timing, re-match, abort and reset.
module tb_vga_sprite_engine;
   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] h_counter;
   logic       line_start, frame_start;
   logic [1:0] color_out;
   logic       sprite_hit;
   logic [1:0] sprite_id;
   logic       collision;
   int vectors = 0;
   int errors  = 0;

   vga_sprite_engine_if wr_bus ();

   vga_sprite_engine dut (
      .clk           (clk),
      .reset         (reset),
      .i_h_counter   (h_counter),
      .i_line_start  (line_start),
      .i_frame_start (frame_start),
      .wr_bus        (wr_bus),
      .o_color_out   (color_out),
      .o_sprite_hit  (sprite_hit),
      .o_sprite_id   (sprite_id),
      .o_collision   (collision)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input int sel, input logic [31:0] pix, input int x,
                            input int scale, input logic flip, input logic en);
      wr_bus.wr_en     = 1'b1;
      wr_bus.wr_sel    = 2'(sel);
      wr_bus.wr_pixels = pix;
      wr_bus.wr_x      = 10'(x);
      wr_bus.wr_scale  = 6'(scale);
      wr_bus.wr_flip   = flip;
      wr_bus.wr_enable = en;
      tick();
      wr_bus.wr_en     = 1'b0;
   endtask

   task automatic commit();
      h_counter  = 10'd0;
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
   endtask

   // Expected colour of one channel in the cycle where h_counter == h.
   function automatic logic [1:0] ref_pix(input logic [31:0] pix, input int x,
                                          input int scale, input logic flip, input int h);
      int off, k, idx;
      off = h - x - 2;
      if (off < 0 || off >= 16 * (scale + 1)) return 2'd0;
      k   = off / (scale + 1);
      idx = flip ? 15 - k : k;
      return pix[idx*2 +: 2];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick();
      vectors++;
      if (color_out !== 2'd0) begin errors++; $display("FAIL reset color_out=%0d expected 0", color_out); end
      vectors++;
      if (sprite_hit !== 1'b0) begin errors++; $display("FAIL reset sprite_hit=%0b expected 0", sprite_hit); end
      vectors++;
      if (sprite_id !== 2'd0) begin errors++; $display("FAIL reset sprite_id=%0d expected 0", sprite_id); end
      vectors++;
      if (collision !== 1'b0) begin errors++; $display("FAIL reset collision=%0b expected 0", collision); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single(input logic [31:0] pix, input int scale, input logic flip,
                              input int hi);
      logic [1:0] e;
      write_cfg(0, pix, 100, scale, flip, 1'b1);
      commit();
      for (int h = 95; h <= hi; h++) begin
         tick();
         h_counter = 10'(h);
         e = ref_pix(pix, 100, scale, flip, h);
         vectors++;
         if (color_out !== e || sprite_hit !== (e != 0) || sprite_id !== 2'd0) begin
            errors++;
            $display("FAIL single s=%0d f=%0b h=%0d color/hit/id=%0d/%0b/%0d expected %0d/%0b/0",
                     scale, flip, h, color_out, sprite_hit, sprite_id, e, e != 0);
         end
      end
   endtask

   task automatic test_overlap(input logic [31:0] p0);
      logic [1:0] c0, c1, ec, ei;
      logic       ecoll, fs_prev, ov;
      write_cfg(0, p0, 100, 0, 1'b0, 1'b1);
      write_cfg(1, 32'hAAAA_AAAA, 108, 0, 1'b0, 1'b1);
      commit();
      ecoll   = 1'b0;
      fs_prev = 1'b0;
      for (int h = 95; h <= 135; h++) begin
         tick();
         h_counter = 10'(h);
         c0 = ref_pix(p0, 100, 0, 1'b0, h);
         c1 = ref_pix(32'hAAAA_AAAA, 108, 0, 1'b0, h);
         ec = (c0 != 0) ? c0 : c1;
         ei = (c0 != 0) ? 2'd0 : ((c1 != 0) ? 2'd1 : 2'd0);
         ov = (c0 != 0) && (c1 != 0);
         ecoll = fs_prev ? ov : (ecoll | ov);
         vectors++;
         if (color_out !== ec || sprite_id !== ei || sprite_hit !== (ec != 0) || collision !== ecoll) begin
            errors++;
            $display("FAIL overlap p0=%h h=%0d color/id/hit/coll=%0d/%0d/%0b/%0b expected %0d/%0d/%0b/%0b",
                     p0, h, color_out, sprite_id, sprite_hit, collision, ec, ei, ec != 0, ecoll);
         end
         frame_start = (h == 112) || (h == 128);
         fs_prev     = frame_start;
      end
      frame_start = 1'b0;
      write_cfg(1, 32'h0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_commit_timing();
      logic [1:0] e;
      write_cfg(0, 32'h5555_5555, 100, 0, 1'b0, 1'b1);
      commit();
      // Write coinciding with line_start: new x waits one more line.
      wr_bus.wr_en = 1'b1; wr_bus.wr_sel = 2'd0; wr_bus.wr_x = 10'd200; wr_bus.wr_scale = 6'd3;
      h_counter = 10'd0; line_start = 1'b1;
      tick();
      line_start = 1'b0; wr_bus.wr_en = 1'b0;
      for (int h = 95; h <= 130; h++) begin
         tick();
         h_counter    = 10'(h);
         wr_bus.wr_en = (h == 105);
         e = ref_pix(32'h5555_5555, 100, 0, 1'b0, h);
         vectors++;
         if (color_out !== e) begin
            errors++;
            $display("FAIL commit_line1 h=%0d color_out=%0d expected %0d", h, color_out, e);
         end
      end
      wr_bus.wr_en = 1'b0;
      commit();
      for (int h = 95; h <= 270; h++) begin
         tick();
         h_counter = 10'(h);
         e = ref_pix(32'h5555_5555, 200, 3, 1'b0, h);
         vectors++;
         if (color_out !== e) begin
            errors++;
            $display("FAIL commit_line2 h=%0d color_out=%0d expected %0d", h, color_out, e);
         end
      end
   endtask

   task automatic test_rematch();
      int j, h;
      logic [1:0] e;
      write_cfg(0, 32'hE4E4_E4E4, 100, 0, 1'b0, 1'b1);
      commit();
      // h revisits 100 at s=10 while the pass is running.
      for (int s = 0; s <= 30; s++) begin
         tick();
         h = (s < 10) ? 95 + s : 90 + s;
         h_counter = 10'(h);
         j = s - 5;
         e = (j >= 2 && j <= 17) ? 2'((j - 2) % 4) : 2'd0;
         vectors++;
         if (color_out !== e) begin
            errors++;
            $display("FAIL rematch step=%0d h=%0d color_out=%0d expected %0d", s, h, color_out, e);
         end
      end
   endtask

   task automatic test_abort();
      logic [1:0] e;
      write_cfg(0, 32'h5555_5555, 100, 0, 1'b0, 1'b1);
      commit();
      for (int h = 95; h <= 125; h++) begin
         tick();
         h_counter  = 10'(h);
         line_start = (h == 105);
         e = (h >= 102 && h <= 106) ? 2'd1 : 2'd0;
         vectors++;
         if (color_out !== e) begin
            errors++;
            $display("FAIL abort h=%0d color_out=%0d expected %0d", h, color_out, e);
         end
      end
      line_start = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [1:0] e;
      logic       ec;
      write_cfg(0, 32'h5555_5555, 100, 0, 1'b0, 1'b1);
      write_cfg(1, 32'hAAAA_AAAA, 100, 0, 1'b0, 1'b1);
      commit();
      for (int h = 95; h <= 125; h++) begin
         tick();
         h_counter = 10'(h);
         reset     = (h == 105);
         e  = (h >= 102 && h <= 105) ? 2'd1 : 2'd0;
         ec = (h >= 102 && h <= 105);
         vectors++;
         if (color_out !== e || sprite_hit !== (e != 0) || sprite_id !== 2'd0 || collision !== ec) begin
            errors++;
            $display("FAIL reset_mid h=%0d color/hit/id/coll=%0d/%0b/%0d/%0b expected %0d/%0b/0/%0b",
                     h, color_out, sprite_hit, sprite_id, collision, e, e != 0, ec);
         end
      end
      reset = 1'b0;
      commit();
      for (int h = 95; h <= 125; h++) begin
         tick();
         h_counter = 10'(h);
         vectors++;
         if (color_out !== 2'd0 || sprite_hit !== 1'b0 || collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle h=%0d color/hit/coll=%0d/%0b/%0b expected 0/0/0",
                     h, color_out, sprite_hit, collision);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; h_counter = '0; line_start = 1'b0; frame_start = 1'b0;
      wr_bus.wr_en = 1'b0; wr_bus.wr_sel = '0; wr_bus.wr_pixels = '0; wr_bus.wr_x = '0;
      wr_bus.wr_scale = '0; wr_bus.wr_flip = 1'b0; wr_bus.wr_enable = 1'b0;
      test_reset();
      test_single(32'h0000_001B, 0, 1'b0, 125);
      test_single(32'h5555_5555, 0, 1'b0, 125);
      test_single(32'h8000_001B, 2, 1'b1, 160);
      test_overlap(32'h5555_5555);
      test_overlap(32'h0000_FFFF);
      test_commit_timing();
      test_rematch();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
